// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared definitions for the data-memory responder slice.
//               These are the FSM state encoding, the word geometry and the
//               alignment mask.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

   // Responder FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

   // Bytes per storage word
   localparam int WORD_BYTES = 4;

   // Low address bits that must be zero for a word access
   localparam logic [1:0] DMEM_ALIGN_MASK = 2'b11;

   // Counter width that covers the full WAIT_CYCLES range (0..15)
   localparam int WAIT_CNT_W = 4;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : Request/response bus between the MEM pipeline stage (master)
//               and the data-memory responder (slave).
//               Request channel  : req_valid/req_ready, req_we, req_addr,
//                                  req_wdata, req_be
//               Response channel : rsp_valid/rsp_ready, rsp_rdata, rsp_err
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
   import dmem_pkg::*;

   logic                    req_valid;
   logic                    req_ready;
   logic                    req_we;
   logic [31:0]             req_addr;
   logic [31:0]             req_wdata;
   logic [WORD_BYTES-1:0]   req_be;

   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [31:0]             rsp_rdata;
   logic                    rsp_err;

   // MEM stage side
   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   // Responder side
   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface : dmem_responder_if
`default_nettype wire

// File: rtl/dmem_bytelane_ram.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bytelane_ram
// Description : DEPTH_WORDS x 32 storage built as one 8-bit array per byte
//               lane. The write is synchronous with per-lane enables. The read
//               data is registered on the edge where rd_en_i is high and held
//               otherwise. Storage is not reset; only the read register is.
// Ports       : clk, rst_n        - clock, async active-low reset
//               idx_i             - word index
//               wr_en_i, be_i     - write strobe and byte-lane enables
//               wdata_i           - write data
//               rd_en_i           - capture read data this edge
//               rdata_o           - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_bytelane_ram
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  wire logic                  clk,
   input  wire logic                  rst_n,
   input  wire logic [IDX_W-1:0]      idx_i,
   input  wire logic                  wr_en_i,
   input  wire logic [WORD_BYTES-1:0] be_i,
   input  wire logic [31:0]           wdata_i,
   input  wire logic                  rd_en_i,
   output logic [31:0]                rdata_o
);

   for (genvar i = 0; i < WORD_BYTES; i++) begin : g_lane
      logic [7:0] mem_q [DEPTH_WORDS];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
         if (wr_en_i && be_i[i]) begin
            mem_q[idx_i] <= wdata_i[8*i +: 8];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rd_q <= 8'h00;
         end else if (rd_en_i) begin
            rd_q <= mem_q[idx_i];
         end
      end

      assign rdata_o[8*i +: 8] = rd_q;
   end

endmodule : dmem_bytelane_ram
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder for MEM-stage loads and stores.
//               It accepts one request at a time. After WAIT_CYCLES it checks
//               alignment and range and then does a byte-masked write or a
//               word read. It returns the result on the response channel and
//               holds it until the requester accepts it.
// Ports       : clk      - system clock
//               rst_n    - asynchronous active-low reset
//               dmem_bus - dmem_responder_if slave modport
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   dmem_responder_if.slave    dmem_bus
);

   localparam int                    c_IDX_W     = $clog2(DEPTH_WORDS);
   // Counter preload. It counts down to 0 so that the access lands exactly
   // WAIT_CYCLES edges after acceptance.
   localparam logic [WAIT_CNT_W-1:0] c_WAIT_LOAD =
      (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

   // Misaligned, or word index beyond storage. The upper address bits take
   // part in the check, so large addresses never alias into storage.
   function automatic logic addr_err(input logic [31:0] a);
      return ((a[1:0] & DMEM_ALIGN_MASK) != 2'b00) ||
             ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS));
   endfunction

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   dmem_state_e               state_q,    state_d;
   logic [WAIT_CNT_W-1:0]     cnt_q,      cnt_d;
   logic                      we_q,       we_d;
   logic [c_IDX_W-1:0]        idx_q,      idx_d;
   logic [31:0]               wdata_q,    wdata_d;
   logic [WORD_BYTES-1:0]     be_q,       be_d;
   logic                      err_q,      err_d;
   logic                      rsp_load_q, rsp_load_d;
   logic                      rsp_err_q,  rsp_err_d;

   // ------------------------------------------------------------------------
   // Combinational signals
   // ------------------------------------------------------------------------
   logic                      w_bus_err;
   logic                      w_from_bus;
   logic                      w_access;
   logic                      w_acc_we;
   logic                      w_acc_err;
   logic [c_IDX_W-1:0]        w_acc_idx;
   logic [31:0]               w_acc_wdata;
   logic [WORD_BYTES-1:0]     w_acc_be;
   logic                      w_ram_wr;
   logic                      w_ram_rd;
   logic [31:0]               w_ram_rdata;
   logic                      w_req_ready;
   logic                      w_rsp_valid;

   assign w_bus_err = addr_err(dmem_bus.req_addr);

   // An access that starts from IDLE can only happen with WAIT_CYCLES == 0.
   // The request has not been latched yet, so it is taken from the bus.
   assign w_from_bus  = (state_q == IDLE);
   assign w_acc_we    = w_from_bus ? dmem_bus.req_we                    : we_q;
   assign w_acc_err   = w_from_bus ? w_bus_err                          : err_q;
   assign w_acc_idx   = w_from_bus ? dmem_bus.req_addr[c_IDX_W+1:2]     : idx_q;
   assign w_acc_wdata = w_from_bus ? dmem_bus.req_wdata                 : wdata_q;
   assign w_acc_be    = w_from_bus ? dmem_bus.req_be                    : be_q;

   assign w_ram_wr = w_access &&  w_acc_we && !w_acc_err;
   assign w_ram_rd = w_access && !w_acc_we && !w_acc_err;

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         idx_q      <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         err_q      <= 1'b0;
         rsp_load_q <= 1'b0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         idx_q      <= idx_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         err_q      <= err_d;
         rsp_load_q <= rsp_load_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state and outputs
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      idx_d       = idx_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      err_d       = err_q;
      rsp_load_d  = rsp_load_q;
      rsp_err_d   = rsp_err_q;
      w_access    = 1'b0;
      w_req_ready = 1'b0;
      w_rsp_valid = 1'b0;

      unique case (state_q)
         IDLE: begin
            w_req_ready = 1'b1;
            if (dmem_bus.req_valid) begin
               we_d    = dmem_bus.req_we;
               idx_d   = dmem_bus.req_addr[c_IDX_W+1:2];
               wdata_d = dmem_bus.req_wdata;
               be_d    = dmem_bus.req_be;
               err_d   = w_bus_err;
               if (WAIT_CYCLES > 0) begin
                  cnt_d   = c_WAIT_LOAD;
                  state_d = WAIT;
               end else begin
                  w_access   = 1'b1;
                  rsp_err_d  = w_bus_err;
                  rsp_load_d = !dmem_bus.req_we && !w_bus_err;
                  state_d    = RESP;
               end
            end
         end

         WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               w_access   = 1'b1;
               rsp_err_d  = err_q;
               rsp_load_d = !we_q && !err_q;
               state_d    = RESP;
            end
         end

         RESP: begin
            w_rsp_valid = 1'b1;
            if (dmem_bus.rsp_ready) begin
               rsp_err_d  = 1'b0;
               rsp_load_d = 1'b0;
               state_d    = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------------
   dmem_bytelane_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (c_IDX_W)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .idx_i   (w_acc_idx),
      .wr_en_i (w_ram_wr),
      .be_i    (w_acc_be),
      .wdata_i (w_acc_wdata),
      .rd_en_i (w_ram_rd),
      .rdata_o (w_ram_rdata)
   );

   // ------------------------------------------------------------------------
   // Bus outputs
   // ------------------------------------------------------------------------
   assign dmem_bus.req_ready = w_req_ready;
   assign dmem_bus.rsp_valid = w_rsp_valid;
   // The RAM read register keeps stale data after stores and errors, so the
   // load flag forces zero in those cases.
   assign dmem_bus.rsp_rdata = rsp_load_q ? w_ram_rdata : 32'h0;
   assign dmem_bus.rsp_err   = rsp_err_q;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. It has three
//               instances: index 0 has WAIT_CYCLES=1, index 1 has
//               WAIT_CYCLES=3 and index 2 has WAIT_CYCLES=0. Expected data
//               comes from a word-array model that is updated with the
//               byte-enable rules. Latency and throughput are derived from
//               WAIT_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

   localparam int DEPTH = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n_v     [3];
   logic        req_valid_v [3];
   logic        req_we_v    [3];
   logic [31:0] req_addr_v  [3];
   logic [31:0] req_wdata_v [3];
   logic [3:0]  req_be_v    [3];
   logic        rsp_ready_v [3];

   wire         req_ready_w [3];
   wire         rsp_valid_w [3];
   wire  [31:0] rsp_rdata_w [3];
   wire         rsp_err_w   [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int WC = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
      dmem_responder_if bus ();
      assign bus.req_valid   = req_valid_v[g];
      assign bus.req_we      = req_we_v[g];
      assign bus.req_addr    = req_addr_v[g];
      assign bus.req_wdata   = req_wdata_v[g];
      assign bus.req_be      = req_be_v[g];
      assign bus.rsp_ready   = rsp_ready_v[g];
      assign req_ready_w[g]  = bus.req_ready;
      assign rsp_valid_w[g]  = bus.rsp_valid;
      assign rsp_rdata_w[g]  = bus.rsp_rdata;
      assign rsp_err_w[g]    = bus.rsp_err;

      dmem_responder #(
         .DEPTH_WORDS (DEPTH),
         .WAIT_CYCLES (WC)
      ) u_dut (
         .clk      (clk),
         .rst_n    (rst_n_v[g]),
         .dmem_bus (bus.slave)
      );
   end

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   logic [31:0] mdl [3][DEPTH];

   always @(negedge clk) cyc <= cyc + 1;

   function automatic int wait_of(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Full transaction. The caller is positioned just after a negedge with
   // the target idle. The task returns just after a negedge, one cycle past
   // the response handshake.
   task automatic txn(input int k, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input int hold, output int acc_cyc);
      logic        exp_err;
      logic [31:0] exp_rd;
      int          idx;
      int          n;
      logic        busy_ok;
      exp_err = (addr % 4 != 0) || (addr >= 32'(DEPTH * 4));
      idx     = int'(addr / 4);
      exp_rd  = 32'h0;
      if (!exp_err) begin
         if (we) begin
            for (int i = 0; i < 4; i++)
               if (be[i]) mdl[k][idx][8*i +: 8] = wdata[8*i +: 8];
         end else begin
            exp_rd = mdl[k][idx];
         end
      end

      req_we_v[k]    = we;
      req_addr_v[k]  = addr;
      req_wdata_v[k] = wdata;
      req_be_v[k]    = be;
      req_valid_v[k] = 1'b1;
      rsp_ready_v[k] = (hold == 0);
      @(posedge clk);
      acc_cyc = cyc;
      @(negedge clk);
      // Drop and scramble the request: the responder must use its latched copy
      req_valid_v[k] = 1'b0;
      req_we_v[k]    = ~we;
      req_addr_v[k]  = $urandom;
      req_wdata_v[k] = $urandom;
      req_be_v[k]    = 4'($urandom);

      n = 1;
      busy_ok = 1'b1;
      while (rsp_valid_w[k] !== 1'b1 && n < 40) begin
         if (req_ready_w[k] !== 1'b0) busy_ok = 1'b0;
         @(negedge clk);
         n++;
      end
      check("latency", n, wait_of(k) + 1);
      check("ready_low_in_wait", busy_ok, 1'b1);
      check("ready_low_in_resp", req_ready_w[k], 1'b0);
      check("rsp_err", rsp_err_w[k], exp_err);
      check("rsp_rdata", rsp_rdata_w[k], exp_rd);

      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("bp_valid", rsp_valid_w[k], 1'b1);
         check("bp_rdata", rsp_rdata_w[k], exp_rd);
         check("bp_err", rsp_err_w[k], exp_err);
         check("bp_ready", req_ready_w[k], 1'b0);
      end
      rsp_ready_v[k] = 1'b1;
      @(negedge clk);
      check("idle_valid", rsp_valid_w[k], 1'b0);
      check("idle_ready", req_ready_w[k], 1'b1);
   endtask

   int          acc, prev_acc, prev_hold, hold, n;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  be;

   initial begin
      #400000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 3; k++) begin
         rst_n_v[k]     = 1'b0;
         req_valid_v[k] = 1'b0;
         req_we_v[k]    = 1'b0;
         req_addr_v[k]  = 32'h0;
         req_wdata_v[k] = 32'h0;
         req_be_v[k]    = 4'h0;
         rsp_ready_v[k] = 1'b0;
      end
      repeat (2) @(negedge clk);
      check("rst_valid", rsp_valid_w[0], 1'b0);
      check("rst_rdata", rsp_rdata_w[0], 32'h0);
      check("rst_err", rsp_err_w[0], 1'b0);
      for (int k = 0; k < 3; k++) rst_n_v[k] = 1'b1;
      @(negedge clk);
      check("rst_ready", req_ready_w[0], 1'b1);

      // Store then load, with byte-lane merge
      txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, acc);
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, acc);
      txn(0, 1'b1, 32'h10, 32'h11223344, 4'h5, 0, acc);
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, acc);
      check("merge_model", mdl[0][4], 32'hDE22BE44);
      txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, acc);

      // Errors: misaligned store, out of range, high-bit address, unchanged data
      txn(0, 1'b1, 32'h12, 32'h55555555, 4'hF, 0, acc);
      txn(0, 1'b0, 32'h1000, 32'h0, 4'h0, 0, acc);
      txn(0, 1'b1, 32'h8000_0010, 32'h66666666, 4'hF, 0, acc);
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, acc);

      // Backpressure for 5 cycles
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, acc);

      // Randomised phase on the WAIT_CYCLES=1 instance
      prev_hold = 0;
      txn(0, 1'b1, 32'h100, $urandom, 4'hF, 0, prev_acc);
      for (int i = 1; i < 16; i++) begin
         txn(0, 1'b1, 32'h100 + 32'(i * 4), $urandom, 4'hF, 0, acc);
         check("thru_preload", acc - prev_acc, wait_of(0) + 2 + prev_hold);
         prev_acc = acc;
      end
      for (int i = 0; i < 40; i++) begin
         n = $urandom_range(0, 9);
         case (n)
            0:       addr = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
            1:       addr = 32'h8000_0100 + (32'($urandom_range(0, 15)) << 2);
            2:       addr = 32'h100 + (32'($urandom_range(0, 15)) << 2)
                            + 32'($urandom_range(1, 3));
            default: addr = 32'h100 + (32'($urandom_range(0, 15)) << 2);
         endcase
         we   = 1'($urandom);
         be   = 4'($urandom);
         hold = $urandom_range(0, 2);
         txn(0, we, addr, $urandom, be, hold, acc);
         check("thru_random", acc - prev_acc, wait_of(0) + 2 + prev_hold);
         prev_acc  = acc;
         prev_hold = hold;
      end

      // Reset during WAIT on the WAIT_CYCLES=3 instance
      txn(1, 1'b1, 32'h20, 32'h0, 4'hF, 0, acc);
      req_we_v[1] = 1'b1; req_addr_v[1] = 32'h20; req_wdata_v[1] = 32'hCAFEF00D;
      req_be_v[1] = 4'hF; req_valid_v[1] = 1'b1; rsp_ready_v[1] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid_v[1] = 1'b0;
      rst_n_v[1] = 1'b0;
      #1;
      check("midrst_valid", rsp_valid_w[1], 1'b0);
      check("midrst_ready", req_ready_w[1], 1'b1);
      check("midrst_err", rsp_err_w[1], 1'b0);
      @(negedge clk);
      rst_n_v[1] = 1'b1;
      @(negedge clk);
      txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 0, acc);

      // Reset during RESP loses the response
      txn(1, 1'b1, 32'h24, 32'h13579BDF, 4'hF, 0, acc);
      req_we_v[1] = 1'b0; req_addr_v[1] = 32'h24; req_valid_v[1] = 1'b1;
      rsp_ready_v[1] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid_v[1] = 1'b0;
      n = 0;
      while (rsp_valid_w[1] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("resp_reached", rsp_rdata_w[1], 32'h13579BDF);
      rst_n_v[1] = 1'b0;
      #1;
      check("resprst_valid", rsp_valid_w[1], 1'b0);
      check("resprst_rdata", rsp_rdata_w[1], 32'h0);
      @(negedge clk);
      rst_n_v[1] = 1'b1;
      @(negedge clk);
      txn(1, 1'b0, 32'h24, 32'h0, 4'h0, 1, acc);

      // WAIT_CYCLES=0: back-to-back with rsp_ready high
      txn(2, 1'b1, 32'h40, 32'hA5A5_0001, 4'hF, 0, prev_acc);
      for (int i = 1; i < 4; i++) begin
         txn(2, 1'b1, 32'h40 + 32'(i * 4), $urandom, 4'hF, 0, acc);
         check("thru_w0", acc - prev_acc, 2);
         prev_acc = acc;
      end
      for (int i = 0; i < 6; i++) begin
         txn(2, 1'b0, 32'h40 + 32'((i % 4) * 4), 32'h0, 4'h0, 0, acc);
         check("thru_w0", acc - prev_acc, 2);
         prev_acc = acc;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_dmem_responder
`default_nettype wire
